// File: rtl/clkdiv_bank.sv
// clkdiv_bank: NCH runtime-programmable even-ratio clock dividers with tick outputs.
// Optional feature macro CLKDIV_SYNC_EN adds a sync input that phase-aligns all channels.

module clkdiv_bank #(
  parameter int NCH      = 4,
  parameter int CW       = 24,
  parameter int DEF_HALF = 1,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_25MHz,
  input  logic           reset,
  input  logic [NCH-1:0] ch_en,
  input  logic           cfg_wr,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_half,
`ifdef CLKDIV_SYNC_EN
  input  logic           sync,
`endif
  output logic           cfg_ack,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);

  localparam int CHW1 = CHW + 1;
  localparam logic [CHW:0] NCH_L = CHW1'(NCH);
  localparam logic [CW-1:0] DEF_L = CW'(DEF_HALF);

  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][CW-1:0] half_q, half_d;
  logic [NCH-1:0][CW-1:0] sh_q, sh_d;
  logic [NCH-1:0]         clk_q, clk_d;
  logic [NCH-1:0]         tick_q, tick_d;
  logic                   ack_q, ack_d;
  logic                   wr_ok;
  logic                   sync_hit;

`ifdef CLKDIV_SYNC_EN
  assign sync_hit = sync;
`else
  assign sync_hit = 1'b0;
`endif

  // channel indices that do not exist are silently dropped
  assign wr_ok = cfg_wr && ({1'b0, cfg_ch} < NCH_L);

  always_comb begin
    ack_d  = wr_ok;
    cnt_d  = cnt_q;
    half_d = half_q;
    sh_d   = sh_q;
    clk_d  = clk_q;
    tick_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wr_ok && (cfg_ch == CHW'(i)))
        sh_d[i] = cfg_half;
      // sh_d already holds a same-cycle write, giving the bypass commit
      if (sync_hit || !ch_en[i]) begin
        cnt_d[i]  = '0;
        clk_d[i]  = 1'b0;
        half_d[i] = sh_d[i];
      end else if (cnt_q[i] == half_q[i]) begin
        cnt_d[i]  = '0;
        clk_d[i]  = ~clk_q[i];
        tick_d[i] = ~clk_q[i];
        half_d[i] = sh_d[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_25MHz or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      half_q <= {NCH{DEF_L}};
      sh_q   <= {NCH{DEF_L}};
      clk_q  <= '0;
      tick_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      sh_q   <= sh_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      ack_q  <= ack_d;
    end
  end

  assign cfg_ack = ack_q;
  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clkdiv_bank.sv
// tb_clkdiv_bank: scoreboard bench for clkdiv_bank; expected tick cycles are
// queued with the stimulus and matched as ticks appear.

module tb_clkdiv_bank;

  localparam int CW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [3:0]    ch_en;
  logic          cfg_wr;
  logic [1:0]    cfg_ch;
  logic [CW-1:0] cfg_half;
  logic          cfg_ack;
  logic [3:0]    clk_out;
  logic [3:0]    tick;
`ifdef CLKDIV_SYNC_EN
  logic          sync;
`endif

  logic [2:0]    ch_en_s;
  logic          cfg_wr_s;
  logic [1:0]    cfg_ch_s;
  logic [CW-1:0] cfg_half_s;
  logic          cfg_ack_s;
  logic [2:0]    clk_out_s;
  logic [2:0]    tick_s;

  clkdiv_bank #(.NCH(4), .CW(CW), .DEF_HALF(1)) dut (
    .clk_25MHz (clk),
    .reset     (rst_n),
    .ch_en     (ch_en),
    .cfg_wr    (cfg_wr),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
`ifdef CLKDIV_SYNC_EN
    .sync      (sync),
`endif
    .cfg_ack   (cfg_ack),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  clkdiv_bank #(.NCH(3), .CW(CW), .DEF_HALF(1)) dut_s (
    .clk_25MHz (clk),
    .reset     (rst_n),
    .ch_en     (ch_en_s),
    .cfg_wr    (cfg_wr_s),
    .cfg_ch    (cfg_ch_s),
    .cfg_half  (cfg_half_s),
`ifdef CLKDIV_SYNC_EN
    .sync      (1'b0),
`endif
    .cfg_ack   (cfg_ack_s),
    .clk_out   (clk_out_s),
    .tick      (tick_s)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;
  int c0 = 0;
  bit mon_small = 1'b0;

  typedef struct packed {
    int ch;
    int t;
  } ev_t;
  ev_t q[$];

  task automatic expect_tick(input int ch, input int t);
    ev_t e;
    e.ch = ch;
    e.t  = t;
    q.push_back(e);
  endtask

  task automatic push_default(input logic [3:0] mask, input int last);
    for (int c = 0; c < 4; c++)
      if (mask[c])
        for (int t = 2; t <= last; t += 4)
          expect_tick(c, c0 + t);
  endtask

  task automatic match(input int ch, input logic lvl);
    int idx;
    idx = -1;
    for (int k = 0; k < q.size(); k++)
      if (idx < 0 && q[k].ch == ch) idx = k;
    compared++;
    if (idx < 0) begin
      mismatched++;
      $display("FAIL tick ch%0d: got tick at cycle %0d, required none",
               ch, cyc - c0);
    end else begin
      if (q[idx].t !== cyc) begin
        mismatched++;
        $display("FAIL tick ch%0d: got tick at cycle %0d, required %0d",
                 ch, cyc - c0, q[idx].t - c0);
      end
      q.delete(idx);
    end
    compared++;
    if (lvl !== 1'b1) begin
      mismatched++;
      $display("FAIL clk_at_tick ch%0d: got %b, required 1", ch, lvl);
    end
  endtask

  task automatic check_ticks();
    for (int c = 0; c < 4; c++)
      if (tick[c] === 1'b1) match(c, clk_out[c]);
    if (mon_small)
      for (int c = 0; c < 3; c++)
        if (tick_s[c] === 1'b1) match(8 + c, clk_out_s[c]);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      check_ticks();
    end
  endtask

  task automatic drain(input string name);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL %s: got %0d required ticks missing, first ch%0d at cycle %0d",
               name, q.size(), q[0].ch, q[0].t - c0);
    end
    q.delete();
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    ch_en      = 4'hF;
    cfg_wr     = 1'b0;
    cfg_ch     = '0;
    cfg_half   = '0;
    ch_en_s    = 3'b111;
    cfg_wr_s   = 1'b0;
    cfg_ch_s   = '0;
    cfg_half_s = '0;
`ifdef CLKDIV_SYNC_EN
    sync       = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    q.delete();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    ch_en    = 4'hF;
    cfg_wr   = 1'b0;
    cfg_ch   = '0;
    cfg_half = '0;
    ch_en_s  = 3'b111;
    cfg_wr_s = 1'b0;
    cfg_ch_s = '0;
    cfg_half_s = '0;
`ifdef CLKDIV_SYNC_EN
    sync     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    compared++;
    if (clk_out !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_clk: got %h, required 0", clk_out);
    end
    compared++;
    if (tick !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_tick: got %h, required 0", tick);
    end
    compared++;
    if (cfg_ack !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ack: got %b, required 0", cfg_ack);
    end
  endtask

  task automatic test_default();
    do_reset();
    push_default(4'hF, 18);
    run(20);
    drain("default");
  endtask

  task automatic test_cfg_write();
    do_reset();
    push_default(4'b1101, 14);
    expect_tick(1, c0 + 2);
    for (int t = 5; t <= 15; t += 2) expect_tick(1, c0 + t);
    run(2);
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_half = '0;
    run(1);
    compared++;
    if (cfg_ack !== 1'b1) begin
      mismatched++;
      $display("FAIL cfg_ack: got %b, required 1", cfg_ack);
    end
    cfg_wr = 1'b0;
    run(1);
    compared++;
    if (cfg_ack !== 1'b0) begin
      mismatched++;
      $display("FAIL cfg_ack_pulse: got %b, required 0", cfg_ack);
    end
    run(12);
    drain("cfg_write");
  endtask

  task automatic test_bypass();
    do_reset();
    push_default(4'b1110, 14);
    expect_tick(0, c0 + 2);
    expect_tick(0, c0 + 8);
    expect_tick(0, c0 + 14);
    run(1);
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_half = 24'd2;
    run(1);
    cfg_wr = 1'b0;
    run(14);
    drain("bypass");
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_default(4'b1011, 10);
    for (int t = 2; t <= 10; t += 2) expect_tick(2, c0 + t);
    cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_half = 24'd5;
    run(1);
    compared++;
    if (cfg_ack !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_ack1: got %b, required 1", cfg_ack);
    end
    cfg_half = 24'd0;
    run(1);
    compared++;
    if (cfg_ack !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_ack2: got %b, required 1", cfg_ack);
    end
    cfg_wr = 1'b0;
    run(1);
    compared++;
    if (cfg_ack !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_ack_end: got %b, required 0", cfg_ack);
    end
    run(8);
    drain("back_to_back");
  endtask

  task automatic test_long_ratio();
    do_reset();
    push_default(4'b0111, 400);
    expect_tick(3, c0 + 2);
    cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_half = 24'd1249999;
    run(1);
    cfg_wr = 1'b0;
    run(399);
    compared++;
    if (clk_out[3] !== 1'b1) begin
      mismatched++;
      $display("FAIL long_hold: got %b, required 1", clk_out[3]);
    end
    drain("long_ratio");
  endtask

  task automatic test_enable();
    do_reset();
    push_default(4'b1011, 18);
    expect_tick(2, c0 + 2);
    expect_tick(2, c0 + 10);
    expect_tick(2, c0 + 18);
    run(3);
    ch_en = 4'b1011;
    cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_half = 24'd3;
    run(1);
    cfg_wr = 1'b0;
    compared++;
    if (clk_out[2] !== 1'b0) begin
      mismatched++;
      $display("FAIL disable_clk: got %b, required 0", clk_out[2]);
    end
    run(2);
    compared++;
    if (clk_out[2] !== 1'b0) begin
      mismatched++;
      $display("FAIL disabled_hold: got %b, required 0", clk_out[2]);
    end
    ch_en = 4'hF;
    run(14);
    drain("enable");
  endtask

  task automatic test_reset_midrun();
    do_reset();
    push_default(4'hF, 2);
    run(2);
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_half = 24'd3;
    run(1);
    cfg_wr = 1'b0;
    compared++;
    if (clk_out !== 4'hF) begin
      mismatched++;
      $display("FAIL pre_reset_clk: got %h, required f", clk_out);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (clk_out !== 4'h0) begin
      mismatched++;
      $display("FAIL midrun_clk: got %h, required 0", clk_out);
    end
    compared++;
    if (cfg_ack !== 1'b0) begin
      mismatched++;
      $display("FAIL midrun_ack: got %b, required 0", cfg_ack);
    end
    drain("pre_midrun");
    do_reset();
    push_default(4'hF, 18);
    run(20);
    drain("after_midrun");
  endtask

  task automatic test_out_of_range();
    do_reset();
    mon_small = 1'b1;
    push_default(4'hF, 14);
    for (int c = 0; c < 3; c++)
      for (int t = 2; t <= 14; t += 4)
        expect_tick(8 + c, c0 + t);
    cfg_wr_s = 1'b1; cfg_ch_s = 2'd3; cfg_half_s = '0;
    run(1);
    cfg_ch_s = 2'd2; cfg_half_s = 24'd1;
    compared++;
    if (cfg_ack_s !== 1'b0) begin
      mismatched++;
      $display("FAIL oor_ack: got %b, required 0", cfg_ack_s);
    end
    run(1);
    cfg_wr_s = 1'b0;
    compared++;
    if (cfg_ack_s !== 1'b1) begin
      mismatched++;
      $display("FAIL inrange_ack: got %b, required 1", cfg_ack_s);
    end
    run(12);
    drain("out_of_range");
    mon_small = 1'b0;
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      expect_tick(c, c0 + ((c == 1) ? 3 : 2));
      expect_tick(c, c0 + 8);
      expect_tick(c, c0 + 12);
    end
    ch_en = 4'b1101;
    run(1);
    ch_en = 4'hF;
    run(4);
    sync = 1'b1;
    run(1);
    sync = 1'b0;
    run(8);
    drain("sync");
  endtask
`endif

  initial begin
    test_reset();
    test_default();
    test_cfg_write();
    test_bypass();
    test_back_to_back();
    test_long_ratio();
    test_enable();
    test_reset_midrun();
    test_out_of_range();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
